// File: rtl/p2_motion.sv
// Player-2 sprite motion/action controller: position, size and action flags,
// all updated once per video frame on the rising edge of vs.
module p2_motion #(
    parameter int         X_MIN         = 53,
    parameter int         X_MAX         = 550,
    parameter int         X_START       = 50,
    parameter int         GROUND_Y      = 291,
    parameter int         TOP_Y         = 103,
    parameter int         X_STEP        = 3,
    parameter int         Y_STEP        = 5,
    parameter int         ATTACK_FRAMES = 8,
    parameter int         RUN_DIV       = 4,
    parameter logic [2:0] PLAY_MODE     = 3'd1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       vs,
    input  logic [7:0] gen_keycode,
    input  logic [2:0] game_mode,
    output logic [9:0] p2_PosX,
    output logic [9:0] p2_PosY,
    output logic [9:0] p2_SizeX,
    output logic [9:0] p2_SizeY,
    output logic       p2_in_air,
    output logic       p2_crouch,
    output logic       p2_move_right,
    output logic       p2_move_left,
    output logic       p2_dir,
    output logic       p2_kick,
    output logic       p2_punch,
    output logic [2:0] p2_run_state
);

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_K = 8'h0E;
    localparam logic [7:0] KEY_P = 8'h13;
    localparam logic [7:0] KEY_R = 8'h15;

    typedef enum logic [1:0] {GROUND, RISE, FALL} vstate_t;

    logic       vs_q_reg;
    vstate_t    vstate_reg, vstate_next;
    logic [9:0] pos_x_reg, pos_x_next;
    logic [9:0] y_reg, y_next;
    logic [9:0] pos_y_reg, pos_y_next;
    logic [9:0] size_x_reg, size_x_next;
    logic [9:0] size_y_reg, size_y_next;
    logic       in_air_reg, in_air_next;
    logic       crouch_reg, crouch_next;
    logic       move_right_reg, move_right_next;
    logic       move_left_reg, move_left_next;
    logic       dir_reg, dir_next;
    logic       kick_reg, kick_next;
    logic       punch_reg, punch_next;
    logic [3:0] atk_cnt_reg, atk_cnt_next;
    logic       armed_reg, armed_next;
    logic [2:0] run_state_reg, run_state_next;
    logic [3:0] run_div_reg, run_div_next;

    logic        tick;
    logic        attack_key;
    logic [10:0] x_ext, y_ext;

    assign tick       = vs & ~vs_q_reg;
    assign attack_key = (gen_keycode == KEY_K) || (gen_keycode == KEY_P);
    assign x_ext      = {1'b0, pos_x_reg};
    assign y_ext      = {1'b0, y_reg};

    always_comb begin
        vstate_next     = vstate_reg;
        pos_x_next      = pos_x_reg;
        y_next          = y_reg;
        in_air_next     = in_air_reg;
        crouch_next     = crouch_reg;
        move_right_next = move_right_reg;
        move_left_next  = move_left_reg;
        dir_next        = dir_reg;
        kick_next       = kick_reg;
        punch_next      = punch_reg;
        atk_cnt_next    = atk_cnt_reg;
        armed_next      = armed_reg;
        run_state_next  = run_state_reg;
        run_div_next    = run_div_reg;

        if (tick && gen_keycode == KEY_R) begin
            vstate_next     = GROUND;
            pos_x_next      = 10'(X_START);
            y_next          = 10'(GROUND_Y);
            in_air_next     = 1'b0;
            crouch_next     = 1'b0;
            move_right_next = 1'b0;
            move_left_next  = 1'b0;
            dir_next        = 1'b0;
            kick_next       = 1'b0;
            punch_next      = 1'b0;
            atk_cnt_next    = 4'd0;
            armed_next      = 1'b1;
            run_state_next  = 3'd0;
            run_div_next    = 4'd0;
        end else if (tick && game_mode == PLAY_MODE) begin
            // Jump is gated by last frame's crouch, so W straight out of a crouch is ignored.
            case (vstate_reg)
                GROUND: begin
                    if (gen_keycode == KEY_W && !crouch_reg) begin
                        vstate_next = RISE;
                        in_air_next = 1'b1;
                    end
                end
                RISE: begin
                    if (y_ext - 11'(Y_STEP) <= 11'(TOP_Y)) begin
                        y_next      = 10'(TOP_Y);
                        vstate_next = FALL;
                    end else begin
                        y_next = 10'(y_ext - 11'(Y_STEP));
                    end
                end
                FALL: begin
                    if (y_ext + 11'(Y_STEP) >= 11'(GROUND_Y)) begin
                        y_next      = 10'(GROUND_Y);
                        vstate_next = GROUND;
                        in_air_next = 1'b0;
                    end else begin
                        y_next = 10'(y_ext + 11'(Y_STEP));
                    end
                end
                default: vstate_next = GROUND;
            endcase

            move_right_next = 1'b0;
            move_left_next  = 1'b0;
            if (gen_keycode == KEY_D && x_ext + 11'(X_STEP) <= 11'(X_MAX)) begin
                pos_x_next      = 10'(x_ext + 11'(X_STEP));
                move_right_next = 1'b1;
                dir_next        = 1'b0;
            end else if (gen_keycode == KEY_A && x_ext - 11'(X_STEP) >= 11'(X_MIN)) begin
                pos_x_next     = 10'(x_ext - 11'(X_STEP));
                move_left_next = 1'b1;
                dir_next       = 1'b1;
            end

            crouch_next = (gen_keycode == KEY_S) && (vstate_reg == GROUND);

            if (atk_cnt_reg != 4'd0) begin
                atk_cnt_next = atk_cnt_reg - 4'd1;
                if (atk_cnt_reg == 4'd1) begin
                    kick_next  = 1'b0;
                    punch_next = 1'b0;
                end
            end else if (attack_key && vstate_reg == GROUND && armed_reg) begin
                atk_cnt_next = 4'(ATTACK_FRAMES);
                kick_next    = (gen_keycode == KEY_K);
                punch_next   = (gen_keycode == KEY_P);
                armed_next   = 1'b0;
            end
            if (!attack_key)
                armed_next = 1'b1;

            if ((move_right_next || move_left_next) && !in_air_next) begin
                if (run_div_reg == 4'(RUN_DIV - 1)) begin
                    run_div_next   = 4'd0;
                    run_state_next = (run_state_reg == 3'd5) ? 3'd0 : run_state_reg + 3'd1;
                end else begin
                    run_div_next = run_div_reg + 4'd1;
                end
            end else begin
                run_div_next   = 4'd0;
                run_state_next = 3'd0;
            end
        end
    end

    // Crouched sprite is shorter but shifted down so its bottom edge stays put.
    assign pos_y_next  = crouch_next ? y_next + 10'd48 : y_next;
    assign size_y_next = crouch_next ? 10'd80 : 10'd128;
    assign size_x_next = ((run_state_next == 3'd3 || run_state_next == 3'd4 ||
                           kick_next || punch_next) && !in_air_next) ? 10'd104 : 10'd64;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vs_q_reg       <= 1'b0;
            vstate_reg     <= GROUND;
            pos_x_reg      <= 10'(X_START);
            y_reg          <= 10'(GROUND_Y);
            pos_y_reg      <= 10'(GROUND_Y);
            size_x_reg     <= 10'd64;
            size_y_reg     <= 10'd128;
            in_air_reg     <= 1'b0;
            crouch_reg     <= 1'b0;
            move_right_reg <= 1'b0;
            move_left_reg  <= 1'b0;
            dir_reg        <= 1'b0;
            kick_reg       <= 1'b0;
            punch_reg      <= 1'b0;
            atk_cnt_reg    <= 4'd0;
            armed_reg      <= 1'b1;
            run_state_reg  <= 3'd0;
            run_div_reg    <= 4'd0;
        end else begin
            vs_q_reg       <= vs;
            vstate_reg     <= vstate_next;
            pos_x_reg      <= pos_x_next;
            y_reg          <= y_next;
            pos_y_reg      <= pos_y_next;
            size_x_reg     <= size_x_next;
            size_y_reg     <= size_y_next;
            in_air_reg     <= in_air_next;
            crouch_reg     <= crouch_next;
            move_right_reg <= move_right_next;
            move_left_reg  <= move_left_next;
            dir_reg        <= dir_next;
            kick_reg       <= kick_next;
            punch_reg      <= punch_next;
            atk_cnt_reg    <= atk_cnt_next;
            armed_reg      <= armed_next;
            run_state_reg  <= run_state_next;
            run_div_reg    <= run_div_next;
        end
    end

    assign p2_PosX       = pos_x_reg;
    assign p2_PosY       = pos_y_reg;
    assign p2_SizeX      = size_x_reg;
    assign p2_SizeY      = size_y_reg;
    assign p2_in_air     = in_air_reg;
    assign p2_crouch     = crouch_reg;
    assign p2_move_right = move_right_reg;
    assign p2_move_left  = move_left_reg;
    assign p2_dir        = dir_reg;
    assign p2_kick       = kick_reg;
    assign p2_punch      = punch_reg;
    assign p2_run_state  = run_state_reg;

endmodule

// File: tb/tb_p2_motion.sv
// Directed bench for p2_motion: reset, jump arc, bounds, crouch, attacks,
// run animation, frame-edge detection, freeze, soft and asynchronous reset.
module tb_p2_motion;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       vs = 1'b0;
    logic [7:0] gen_keycode = 8'h00;
    logic [2:0] game_mode = 3'd1;
    logic [9:0] p2_PosX, p2_PosY, p2_SizeX, p2_SizeY;
    logic       p2_in_air, p2_crouch, p2_move_right, p2_move_left;
    logic       p2_dir, p2_kick, p2_punch;
    logic [2:0] p2_run_state;

    int checks = 0;
    int fails  = 0;

    p2_motion dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .vs           (vs),
        .gen_keycode  (gen_keycode),
        .game_mode    (game_mode),
        .p2_PosX      (p2_PosX),
        .p2_PosY      (p2_PosY),
        .p2_SizeX     (p2_SizeX),
        .p2_SizeY     (p2_SizeY),
        .p2_in_air    (p2_in_air),
        .p2_crouch    (p2_crouch),
        .p2_move_right(p2_move_right),
        .p2_move_left (p2_move_left),
        .p2_dir       (p2_dir),
        .p2_kick      (p2_kick),
        .p2_punch     (p2_punch),
        .p2_run_state (p2_run_state)
    );

    always #5 CLK = ~CLK;

    // One video frame: vs high for one cycle, outputs sampled on a falling edge.
    task automatic frame(input logic [7:0] k);
        @(negedge CLK);
        gen_keycode = k;
        vs = 1'b1;
        @(negedge CLK);
        vs = 1'b0;
        @(negedge CLK);
        $display("frame key=%02h mode=%0d x=%0d y=%0d sz=%0dx%0d air=%0b cr=%0b mr=%0b ml=%0b dir=%0b k=%0b p=%0b run=%0d",
                 k, game_mode, p2_PosX, p2_PosY, p2_SizeX, p2_SizeY, p2_in_air, p2_crouch,
                 p2_move_right, p2_move_left, p2_dir, p2_kick, p2_punch, p2_run_state);
    endtask

    task automatic test_reset;
        checks++;
        if ({p2_PosX, p2_PosY, p2_SizeX, p2_SizeY} !== {10'd50, 10'd291, 10'd64, 10'd128}) begin
            fails++;
            $display("FAIL reset_geom: got x=%0d y=%0d sz=%0dx%0d, want 50 291 64x128",
                     p2_PosX, p2_PosY, p2_SizeX, p2_SizeY);
        end
        checks++;
        if ({p2_in_air, p2_crouch, p2_move_right, p2_move_left, p2_dir, p2_kick, p2_punch, p2_run_state} !== 10'd0) begin
            fails++;
            $display("FAIL reset_flags: got %b, want 0", {p2_in_air, p2_crouch, p2_move_right,
                     p2_move_left, p2_dir, p2_kick, p2_punch, p2_run_state});
        end
    endtask

    task automatic test_left_bound;
        frame(8'h04);  // 50 - 3 < 53: no move
        checks++;
        if ({p2_PosX, p2_move_left, p2_dir} !== {10'd50, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL left_bound: got x=%0d ml=%0b dir=%0b, want 50 0 0", p2_PosX, p2_move_left, p2_dir);
        end
    endtask

    task automatic test_jump;
        frame(8'h1A);
        checks++;
        if ({p2_in_air, p2_PosY} !== {1'b1, 10'd291}) begin
            fails++;
            $display("FAIL jump_start: got air=%0b y=%0d, want 1 291", p2_in_air, p2_PosY);
        end
        repeat (37) frame(8'h00);
        checks++;
        if (p2_PosY !== 10'd106) begin
            fails++;
            $display("FAIL jump_rise37: got y=%0d, want 106", p2_PosY);
        end
        frame(8'h00);
        checks++;
        if ({p2_in_air, p2_PosY} !== {1'b1, 10'd103}) begin
            fails++;
            $display("FAIL jump_apex: got air=%0b y=%0d, want 1 103", p2_in_air, p2_PosY);
        end
        repeat (37) frame(8'h00);
        checks++;
        if ({p2_in_air, p2_PosY} !== {1'b1, 10'd288}) begin
            fails++;
            $display("FAIL jump_fall37: got air=%0b y=%0d, want 1 288", p2_in_air, p2_PosY);
        end
        frame(8'h00);
        checks++;
        if ({p2_in_air, p2_PosY, p2_PosX} !== {1'b0, 10'd291, 10'd50}) begin
            fails++;
            $display("FAIL jump_land: got air=%0b y=%0d x=%0d, want 0 291 50", p2_in_air, p2_PosY, p2_PosX);
        end
    endtask

    task automatic test_crouch;
        frame(8'h16);
        checks++;
        if ({p2_crouch, p2_SizeY, p2_PosY} !== {1'b1, 10'd80, 10'd339}) begin
            fails++;
            $display("FAIL crouch_on: got cr=%0b szy=%0d y=%0d, want 1 80 339", p2_crouch, p2_SizeY, p2_PosY);
        end
        frame(8'h1A);  // jump straight out of a crouch is ignored
        checks++;
        if ({p2_in_air, p2_crouch, p2_SizeY, p2_PosY} !== {1'b0, 1'b0, 10'd128, 10'd291}) begin
            fails++;
            $display("FAIL crouch_nojump: got air=%0b cr=%0b szy=%0d y=%0d, want 0 0 128 291",
                     p2_in_air, p2_crouch, p2_SizeY, p2_PosY);
        end
        frame(8'h00);
    endtask

    task automatic test_attacks;
        int high_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            frame(8'h0E);
            if (p2_kick === 1'b1) high_cnt++;
            checks++;
            if ({p2_kick, p2_punch, p2_SizeX} !== {(i < 8), 1'b0, (i < 8) ? 10'd104 : 10'd64}) begin
                fails++;
                $display("FAIL kick_hold[%0d]: got k=%0b p=%0b szx=%0d, want %0b 0 %0d",
                         i, p2_kick, p2_punch, p2_SizeX, (i < 8), (i < 8) ? 104 : 64);
            end
        end
        checks++;
        if (high_cnt !== 8) begin
            fails++;
            $display("FAIL kick_len: got %0d frames, want 8", high_cnt);
        end
        frame(8'h00);
        frame(8'h0E);
        checks++;
        if (p2_kick !== 1'b1) begin
            fails++;
            $display("FAIL kick_retrigger: got k=%0b, want 1", p2_kick);
        end
        repeat (8) frame(8'h00);
        checks++;
        if (p2_kick !== 1'b0) begin
            fails++;
            $display("FAIL kick_clear: got k=%0b, want 0", p2_kick);
        end
        frame(8'h13);
        checks++;
        if ({p2_punch, p2_kick, p2_SizeX} !== {1'b1, 1'b0, 10'd104}) begin
            fails++;
            $display("FAIL punch: got p=%0b k=%0b szx=%0d, want 1 0 104", p2_punch, p2_kick, p2_SizeX);
        end
        repeat (8) frame(8'h00);
        checks++;
        if (p2_punch !== 1'b0) begin
            fails++;
            $display("FAIL punch_clear: got p=%0b, want 0", p2_punch);
        end
    endtask

    task automatic test_run_right_bound;
        int run_exp;
        for (int n = 1; n <= 166; n++) begin
            frame(8'h07);
            run_exp = (n / 4) % 6;
            checks++;
            if ({p2_PosX, p2_move_right, p2_dir, p2_run_state, p2_SizeX} !==
                {10'(50 + 3 * n), 1'b1, 1'b0, 3'(run_exp),
                 (run_exp == 3 || run_exp == 4) ? 10'd104 : 10'd64}) begin
                fails++;
                $display("FAIL run[%0d]: got x=%0d mr=%0b dir=%0b run=%0d szx=%0d, want %0d 1 0 %0d",
                         n, p2_PosX, p2_move_right, p2_dir, p2_run_state, p2_SizeX, 50 + 3 * n, run_exp);
            end
        end
        frame(8'h07);  // 548 + 3 > 550: held at bound
        checks++;
        if ({p2_PosX, p2_move_right, p2_dir, p2_run_state} !== {10'd548, 1'b0, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL right_bound: got x=%0d mr=%0b dir=%0b run=%0d, want 548 0 0 0",
                     p2_PosX, p2_move_right, p2_dir, p2_run_state);
        end
        frame(8'h04);
        checks++;
        if ({p2_PosX, p2_move_left, p2_move_right, p2_dir} !== {10'd545, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL move_left: got x=%0d ml=%0b mr=%0b dir=%0b, want 545 1 0 1",
                     p2_PosX, p2_move_left, p2_move_right, p2_dir);
        end
    endtask

    task automatic test_vs_edge;
        @(negedge CLK);
        gen_keycode = 8'h07;
        vs = 1'b1;
        repeat (4) @(negedge CLK);
        vs = 1'b0;
        @(negedge CLK);
        checks++;
        if ({p2_PosX, p2_dir} !== {10'd548, 1'b0}) begin
            fails++;
            $display("FAIL vs_edge: got x=%0d dir=%0b, want 548 0", p2_PosX, p2_dir);
        end
        frame(8'h00);
    endtask

    task automatic test_freeze_soft_reset;
        game_mode = 3'd0;
        frame(8'h04);
        checks++;
        if ({p2_PosX, p2_dir, p2_move_left} !== {10'd548, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL freeze: got x=%0d dir=%0b ml=%0b, want 548 0 0", p2_PosX, p2_dir, p2_move_left);
        end
        frame(8'h15);
        checks++;
        if ({p2_PosX, p2_PosY, p2_SizeX, p2_SizeY, p2_dir} !== {10'd50, 10'd291, 10'd64, 10'd128, 1'b0}) begin
            fails++;
            $display("FAIL soft_reset: got x=%0d y=%0d sz=%0dx%0d dir=%0b, want 50 291 64x128 0",
                     p2_PosX, p2_PosY, p2_SizeX, p2_SizeY, p2_dir);
        end
        game_mode = 3'd1;
    endtask

    task automatic test_async_reset;
        frame(8'h1A);
        repeat (5) frame(8'h00);
        frame(8'h07);  // rise continues: 266 - 5 = 261, x moves in the air
        checks++;
        if ({p2_PosY, p2_PosX, p2_in_air, p2_run_state, p2_SizeX} !== {10'd261, 10'd53, 1'b1, 3'd0, 10'd64}) begin
            fails++;
            $display("FAIL air_move: got y=%0d x=%0d air=%0b run=%0d szx=%0d, want 261 53 1 0 64",
                     p2_PosY, p2_PosX, p2_in_air, p2_run_state, p2_SizeX);
        end
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        test_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        frame(8'h00);
        checks++;
        if ({p2_in_air, p2_PosY, p2_PosX} !== {1'b0, 10'd291, 10'd50}) begin
            fails++;
            $display("FAIL post_reset: got air=%0b y=%0d x=%0d, want 0 291 50", p2_in_air, p2_PosY, p2_PosX);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        test_reset();
        RESET_N = 1'b1;
        frame(8'h00);
        test_reset();
        test_left_bound();
        test_jump();
        test_crouch();
        test_attacks();
        test_run_right_bound();
        test_vs_edge();
        test_freeze_soft_reset();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/p2_motion.md
Name: p2_motion

Overview:
- Player-2 motion and action controller, directly downstream of the player-2 Avalon-MM keycode register block.
- Consumes the `gen_keycode[7:0]` and `game_mode[2:0]` exports from that block, plus the VGA vertical sync.
- Produces the sprite position, size and action flags used by the sprite/collision logic.
- All state updates once per video frame; everything runs on the 50 MHz CLK.

Parameters:
- X_MIN, 53, left bound for pos_x
- X_MAX, 550, right bound for pos_x
- X_START, 50, pos_x after reset or soft reset
- GROUND_Y, 291, pos_y when standing
- TOP_Y, 103, jump apex
- X_STEP, 3, horizontal pixels per frame
- Y_STEP, 5, vertical pixels per frame
- ATTACK_FRAMES, 8, frames a kick or punch is held
- RUN_DIV, 4, frames per run_state advance
- PLAY_MODE, 3'd1, game_mode value that enables motion

Ports:
- CLK  in  1  50 MHz system clock
- RESET_N  in  1  reset; asynchronous assert, active-low
- vs  in  1  VGA vertical sync, synchronous to CLK
- gen_keycode  in  8  current player-2 keycode
- game_mode  in  3  current game mode
- p2_PosX  out  10  sprite left x
- p2_PosY  out  10  sprite top y
- p2_SizeX  out  10  sprite width, 64 or 104
- p2_SizeY  out  10  sprite height, 128 or 80
- p2_in_air  out  1  high while jumping
- p2_crouch  out  1  crouching
- p2_move_right  out  1  moved right this frame
- p2_move_left  out  1  moved left this frame
- p2_dir  out  1  facing: 0 right, 1 left
- p2_kick  out  1  kick active
- p2_punch  out  1  punch active
- p2_run_state  out  3  run animation index, 0..5

Behaviour:
- Reset values (all outputs, asynchronous on RESET_N low):
  - p2_PosX = X_START, p2_PosY = GROUND_Y, p2_SizeX = 64, p2_SizeY = 128.
  - All flags 0, p2_run_state = 0, vertical FSM = GROUND, attack counter = 0.
- Frame tick:
  - `tick` = vs & ~vs_q, where vs_q is vs registered one cycle.
  - All state updates only on CLK edges where tick = 1.
  - Outputs are registered and change the cycle after tick.
  - Tick is internal; no handshake with upstream.
- Keycodes: W 8'h1A jump, S 8'h16 crouch, D 8'h07 right, A 8'h04 left, K 8'h0E kick, P 8'h13 punch, R 8'h15 soft reset. Any other code means idle.
- Soft reset (R on a tick, in any game_mode): next state equals the reset values. Takes priority over everything else.
- Freeze: on a tick with game_mode != PLAY_MODE and no R, all state holds.
- Vertical FSM (GROUND, RISE, FALL):
  - GROUND: W with crouch = 0 → RISE, in_air = 1.
  - RISE: if y − Y_STEP ≤ TOP_Y then y = TOP_Y and go to FALL; else y −= Y_STEP.
  - FALL: if y + Y_STEP ≥ GROUND_Y then y = GROUND_Y, go to GROUND, in_air = 0; else y += Y_STEP.
  - W while in RISE or FALL is ignored.
- Horizontal movement (allowed in any vertical state):
  - D and x + X_STEP ≤ X_MAX: x += X_STEP, move_right = 1, move_left = 0, dir = 0.
  - A and x − X_STEP ≥ X_MIN: x −= X_STEP, move_left = 1, move_right = 0, dir = 1.
  - Otherwise both move flags = 0, x holds, dir holds.
  - At the bound, x stays put and never wraps. All 10-bit arithmetic is done in 11 bits before comparing.
- Crouch:
  - crouch = 1 iff keycode is S and state is GROUND; it clears on the first tick without S.
  - While crouched: p2_SizeY = 80 and p2_PosY = y + 48, so the sprite bottom stays fixed.
- Attacks:
  - Trigger: a K or P tick, state GROUND, counter = 0, and armed = 1.
  - On trigger: kick or punch = 1, counter = ATTACK_FRAMES, armed = 0.
  - The counter decrements each tick; the flag clears when it reaches 0.
  - armed is set on any tick whose keycode is neither K nor P. Holding a key therefore does not retrigger.
  - Kick and punch are never both high.
  - Entering RISE does not cancel an active attack.
- run_state:
  - Advances 0→1→…→5→0 every RUN_DIV ticks while (move_right | move_left) and !in_air.
  - Otherwise it and its divider are forced to 0.
- p2_SizeX:
  - 104 when (run_state == 3 | run_state == 4 | kick | punch) and !in_air; else 64.
  - Computed from the state updated on the same tick.

Test Plan:
- Reset: RESET_N low mid-jump → within the same cycle PosX = 50, PosY = 291, Size = 64×128, all flags 0.
- Jump: keycode 1A for one tick, then 00 → in_air = 1; PosY reaches 103 after 38 ticks (last step clamped); returns to 291 after 38 more ticks; in_air = 0.
- Right bound: start PosX = 547, hold 07 for 3 ticks → PosX = 550, move_right = 1 then 0, dir = 0.
- Kick retrigger: hold 0E for 20 ticks → kick high exactly 8 ticks, SizeX = 104 during them; release to 00 for 1 tick, then 0E → kick restarts.
- Freeze/soft reset: game_mode = 0 with keycode 07 → PosX unchanged; keycode 15 → PosX = 50 on the next tick.
- Crouch: hold 16 at ground → SizeY = 80, PosY = 339; jump key 1A while crouched → no jump.
